// File: rtl/divider_pkg.sv
// divider_pkg: shared widths, state encoding and sizing helper for the divider
package divider_pkg;
  localparam int DIV_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration on the {R,Q} pair
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);
  logic [2*WIDTH:0] s;
  logic [WIDTH:0]   t;
  // shift left, trial subtract, keep the difference only when it did not borrow
  always_comb begin
    s   = {r_i, q_i} << 1;
    t   = s[2*WIDTH:WIDTH] - {1'b0, d_i};
    r_o = t[WIDTH] ? s[2*WIDTH:WIDTH] : t;
    q_o = s[WIDTH-1:0] | WIDTH'(!t[WIDTH]);
  end
endmodule

// File: rtl/divider.sv
// divider: sequential restoring divider, 2*WIDTH/WIDTH -> WIDTH quotient and remainder
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d, dvs_q, quo_q, rem_q;
  logic             pdbz_q, povf_q, busy_q, done_q, dbz_q, ovf_q;
  logic             dz, ov;
  assign dz = (divisor == '0);
  assign ov = !dz && (dividend[2*WIDTH-1:WIDTH] >= divisor);
  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i(r_q),
    .q_i(q_q),
    .d_i(dvs_q),
    .r_o(r_d),
    .q_o(q_d)
  );
  // control FSM; error cases take one pass through RUN so they complete after one edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      pdbz_q  <= 1'b0;
      povf_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          dvs_q   <= divisor;
          dbz_q   <= 1'b0;
          ovf_q   <= 1'b0;
          pdbz_q  <= dz;
          povf_q  <= ov;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          r_q     <= dz ? {1'b0, dividend[WIDTH-1:0]} : ov ? '0 : {1'b0, dividend[2*WIDTH-1:WIDTH]};
          q_q     <= (dz || ov) ? '1 : dividend[WIDTH-1:0];
          state_q <= RUN;
        end
        RUN: if (pdbz_q || povf_q) begin
          quo_q   <= q_q;
          rem_q   <= r_q[WIDTH-1:0];
          dbz_q   <= pdbz_q;
          ovf_q   <= povf_q;
          done_q  <= 1'b1;
          state_q <= DONE;
        end else begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            quo_q   <= q_d;
            rem_q   <= r_d[WIDTH-1:0];
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
endmodule
